// File: rtl/i2s_frame_transmitter.sv
// i2s_frame_transmitter
// Serializes stereo PCM sample pairs into a Philips I2S stream (SCK, WS, SD).
// The block runs on the I2S PLL clock, stays idle until the PLL reports lock,
// and buffers incoming pairs in a small FIFO. A frame that starts with the
// FIFO empty is sent as silence and counted as an underrun.
//
// Frame timing (W = SAMPLE_WIDTH, cnt = 0 .. 4W-1):
//   i2s_sck = cnt[0]; slot = cnt >> 1 (0 .. 2W-1).
//   WS and SD only change on a falling SCK edge (cnt odd -> even).
//   The falling edge entering slot 1 loads {left, right} into the shifter;
//   every later falling edge shifts it left by one. Slot 0 therefore still
//   carries the right LSB of the previous frame, as Philips I2S requires.

`timescale 1ns/1ps

module i2s_frame_transmitter #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SAMPLE_WIDTH-1:0] in_left,
   input  logic [SAMPLE_WIDTH-1:0] in_right,
   output logic                    i2s_sck,
   output logic                    i2s_ws,
   output logic                    i2s_sd,
   output logic                    underrun,
   output logic [15:0]             underrun_count
);

   localparam int W  = SAMPLE_WIDTH;
   localparam int FW = 2 * SAMPLE_WIDTH;           // shifter / FIFO entry width
   localparam int CW = $clog2(4 * SAMPLE_WIDTH);   // frame counter width
   localparam int SW = CW - 1;                     // slot index width
   localparam int AW = $clog2(FIFO_DEPTH);         // FIFO address width
   localparam int PW = AW + 1;                     // pointer width (wrap bit)

   localparam logic [PW-1:0] DEPTH_P    = PW'(FIFO_DEPTH);
   localparam logic [SW-1:0] LOAD_SLOT  = SW'(1);
   localparam logic [SW-1:0] RIGHT_SLOT = SW'(W);

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end
      return v + 16'd1;
   endfunction

   // Lock synchronizer
   logic [1:0]    sync_q, sync_d;
   logic          locked_s;

   // Frame timing
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_nxt;
   logic [SW-1:0] next_slot;
   logic          fall_edge;
   logic          load;

   // Serializer and underrun accounting
   logic          ws_q, ws_d;
   logic [FW-1:0] sh_q, sh_d;
   logic          underrun_q, underrun_d;
   logic [15:0]   ucnt_q, ucnt_d;

   // Sample-pair FIFO
   logic [FW-1:0] mem_q [FIFO_DEPTH];
   logic [FW-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   assign locked_s = sync_q[1];

   // Status and handshake derived purely from registered state
   always_comb begin
      fifo_count = wr_ptr_q - rd_ptr_q;
      fifo_full  = (fifo_count == DEPTH_P);
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      in_ready   = locked_s & ~fifo_full;
      push       = in_valid & in_ready;
   end

   // Lock synchronizer shift and frame counter; the counter is parked at 0 while unlocked
   always_comb begin
      sync_d    = {sync_q[0], pll_locked};
      cnt_nxt   = cnt_q + CW'(1);
      cnt_d     = locked_s ? cnt_nxt : '0;
      next_slot = cnt_nxt[CW-1:1];
      fall_edge = locked_s & cnt_q[0];
      load      = fall_edge & (next_slot == LOAD_SLOT);
      pop       = load & ~fifo_empty;
   end

   // Word select, shifter and underrun bookkeeping, all updated on falling SCK edges
   always_comb begin
      ws_d       = ws_q;
      sh_d       = sh_q;
      underrun_d = 1'b0;
      ucnt_d     = ucnt_q;
      if (!locked_s) begin
         // Lost or no lock: truncate the frame and drive a quiet bus.
         ws_d = 1'b0;
         sh_d = '0;
      end else if (fall_edge) begin
         ws_d = (next_slot >= RIGHT_SLOT);
         if (load) begin
            if (fifo_empty) begin
               // Emptiness comes from registered pointers, so a push landing
               // in this same cycle waits for the next frame.
               sh_d       = '0;
               underrun_d = 1'b1;
               ucnt_d     = sat_inc16(ucnt_q);
            end else begin
               sh_d = mem_q[rd_ptr_q[AW-1:0]];
            end
         end else begin
            sh_d = {sh_q[FW-2:0], 1'b0};
         end
      end
   end

   // FIFO pointer movement; pointers are cleared whenever lock is absent
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (!locked_s) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
      end
   end

   // FIFO storage write port
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {in_left, in_right};
      end
   end

   // Control and serializer state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         ws_q       <= 1'b0;
         sh_q       <= '0;
         underrun_q <= 1'b0;
         ucnt_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         ws_q       <= ws_d;
         sh_q       <= sh_d;
         underrun_q <= underrun_d;
         ucnt_q     <= ucnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO payload storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign i2s_sck        = cnt_q[0];
   assign i2s_ws         = ws_q;
   assign i2s_sd         = sh_q[FW-1];
   assign underrun       = underrun_q;
   assign underrun_count = ucnt_q;

endmodule
